// File: rtl/regfile_rdport_arb.sv
// Round-robin arbiter for a shared 32x32 register-file read port. The winning address drives
// the read mux select, and the mux output is captured into a single-entry response buffer.
module regfile_rdport_arb #(
  parameter int unsigned NREQ    = 4,
  parameter bit          ZERO_R0 = 1'b1,
  localparam int unsigned IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [4:0]        rd_sel,
  input  logic [31:0]       rd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [4:0]        resp_addr,
  output logic [31:0]       resp_data
);

  localparam logic [IDW:0] NreqW = (IDW+1)'(NREQ);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  off;
  logic [IDW:0]    sum;
  logic [IDW-1:0]  win;
  logic            any_req;
  logic [4:0]      win_addr;
  logic            can_accept;
  logic            grant;
  logic [31:0]     cap_data;

  logic            resp_valid_q;
  logic [IDW-1:0]  resp_id_q;
  logic [4:0]      resp_addr_q;
  logic [31:0]     resp_data_q;

  // Rotate so bit 0 is the requester at ptr; the first set bit is the offset of the winner.
  always_comb begin
    rot     = NREQ'({req_valid, req_valid} >> ptr_q);
    off     = '0;
    any_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req && rot[i]) begin
        any_req = 1'b1;
        off     = IDW'(i);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    win = (sum >= NreqW) ? IDW'(sum - NreqW) : IDW'(sum);
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        win_addr = req_addr[5*i +: 5];
      end
    end
  end

  assign can_accept = !resp_valid_q || resp_ready;
  assign grant      = can_accept && any_req && rst_n;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (win == IDW'(i));
    end
  end

  // Select is pre-positioned even under back-pressure so the read is ready when the slot frees.
  assign rd_sel   = (rst_n && any_req) ? win_addr : 5'd0;
  assign cap_data = (ZERO_R0 && (win_addr == 5'd0)) ? 32'h0000_0000 : rd_data;
  assign ptr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
    end else if (grant) begin
      ptr_q        <= ptr_d;
      resp_valid_q <= 1'b1;
      resp_id_q    <= win;
      resp_addr_q  <= win_addr;
      resp_data_q  <= cap_data;
    end else if (resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_addr  = resp_addr_q;
  assign resp_data  = resp_data_q;

endmodule

// File: doc/regfile_rdport_arb.md
Name: regfile_rdport_arb

Overview:
- Round-robin arbiter and sequencer for one shared register-file read port. The read port is the 32-entry x 32-bit, 5-bit-select read mux.
- Several requesters (decode stage, debug port, CSR/trace unit, ...) post 5-bit register addresses.
- The block drives the mux select, captures the mux output in a response register, and returns data tagged with the requester ID.
- Uses a valid/ready handshake on both sides, with a single-entry output buffer that holds data under back-pressure.

Parameters:
NREQ, 4, number of requesters; legal range 2..8
ZERO_R0, 1, when 1 a read of address 0 returns 32'h0000_0000 regardless of rd_data
IDW, $clog2(NREQ) (localparam), width of requester ID

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active low
req_valid  input  NREQ  bit i = requester i has a pending read
req_addr  input  5*NREQ  requester i address in bits [5*i+4:5*i]
req_ready  output  NREQ  one-hot grant; bit i high = requester i accepted this cycle
rd_sel  output  5  select driven to the read mux
rd_data  input  32  combinational mux output for rd_sel
resp_valid  output  1  response register holds valid data
resp_ready  input  1  consumer accepts response this cycle
resp_id  output  IDW  requester index of held response
resp_addr  output  5  register address of held response
resp_data  output  32  read data of held response

Behaviour:
- Reset (rst_n=0 sampled at a rising edge):
  - resp_valid=0, resp_id=0, resp_addr=0, resp_data=0, round-robin pointer ptr=0.
  - While rst_n=0, req_ready is forced to all zeros and rd_sel=0.
- Slot free:
  - can_accept = !resp_valid || resp_ready.
  - The buffer may be refilled in the same cycle it drains, so full throughput is 1 read per cycle.
- Arbitration (combinational):
  - Scan requesters in order ptr, ptr+1, ..., wrapping modulo NREQ.
  - The first with req_valid=1 is the winner W.
  - grant = can_accept && (some req_valid) && rst_n.
  - req_ready = grant ? (1<<W) : 0. At most one bit is ever high.
- Mux select:
  - rd_sel = req_addr[W] whenever any req_valid is set. This holds even when can_accept=0, so the read is pre-positioned.
  - rd_sel = 0 when no request is pending.
- On a clock edge with grant=1:
  - resp_data <= (ZERO_R0 && addr==0) ? 0 : rd_data.
  - resp_addr <= addr; resp_id <= W; resp_valid <= 1; ptr <= (W+1) mod NREQ.
- Latency: data is visible on resp_* exactly 1 cycle after the req_ready handshake.
- On an edge with grant=0 and resp_ready=1: resp_valid <= 0. Data/ID/addr registers hold their old values.
- On an edge with grant=0 and resp_ready=0: all response registers hold. resp_data must not change while resp_valid=1 && resp_ready=0.
- ptr changes only on a grant. It does not advance on idle cycles or back-pressure.
- Fairness: a requester holding req_valid continuously is granted within NREQ grants.
- Requester protocol: once req_valid is raised, the requester holds it and req_addr stable until req_ready. The block does not check this.
- resp_ready with resp_valid=0 is ignored.
- Reset mid-operation: the held response is discarded (resp_valid=0 next cycle) and ptr returns to 0. No grant occurs in the reset cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0, rd_sel=0 and resp_valid=0 throughout; after release, first grant goes to req 0.
- Single read: regfile entry 5 = 32'hDEAD_BEEF, req 2 posts addr 5 with resp_ready=1 -> req_ready=4'b0100 in cycle t, rd_sel=5; at t+1 resp_valid=1, resp_id=2, resp_addr=5, resp_data=32'hDEAD_BEEF.
- Round-robin: all 4 requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0,1,... with one grant per cycle; 8 responses in 8 consecutive cycles.
- Back-pressure: resp_ready=0 for 3 cycles with req 1 and req 3 pending -> one response held stable with data unchanged, req_ready=0 and ptr frozen; on resp_ready=1, the next grant occurs in the same cycle as the drain.
- R0 handling: regfile entry 0 = 32'h1234_5678 (forced in the mux model), read addr 0 -> ZERO_R0=1 gives resp_data=0; ZERO_R0=0 gives resp_data=32'h1234_5678.
- Reset mid-flight: resp_valid=1 held with resp_ready=0, then assert rst_n=0 for one cycle -> resp_valid=0 and ptr=0 next cycle; a pending req 3 is granted only after rst_n returns high.
